wb_stage: RTL and testbench

- Write-back stage of the 5-stage MIPS pipeline. Sits directly downstream of MEM_Stage and consumes its MEM/WB outputs.
- Holds the MEM/WB pipeline latch and selects the memory or ALU result.
- Aligns and extends sub-word loads, then drives a registered write port into the ID-stage register file.
- Also exposes a forwarding tap for hazard logic and a sticky misalignment flag.

---
 rtl/wb_stage.sv | 198 +++++++++++++++++++
 tb/tb_wb_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// MIPS write-back stage: MEM/WB latch, load alignment/extension, registered RF write port.
// Define WB_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired_count is 0.
`timescale 1ns/1ps
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_mem_to_reg,
  input  logic              in_reg_write,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_address,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [1:0]        in_load_mode,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [1:0]        rf_load_mode,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  retired_count
);

  logic              s1Valid_q, s1Valid_d;
  logic              s1MemToReg_q, s1MemToReg_d;
  logic              s1RegWrite_q, s1RegWrite_d;
  logic [DATA_W-1:0] s1ReadData_q, s1ReadData_d;
  logic [DATA_W-1:0] s1Address_q, s1Address_d;
  logic [REG_AW-1:0] s1Dest_q, s1Dest_d;
  logic [1:0]        s1LoadMode_q, s1LoadMode_d;

  logic              rfWe_q, rfWe_d;
  logic [REG_AW-1:0] rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
  logic [1:0]        rfLoadMode_q, rfLoadMode_d;
  logic              misalign_q, misalign_d;

  logic [15:0]       halfSel;
  logic [7:0]        byteSel;
  logic [DATA_W-1:0] wbValue;
  logic              s1Writes;
  logic              s1Misalign;
  logic              s2Capture;

  // flush overrides stall so a squashed instruction can never linger in the latch
  always_comb begin
    s1Valid_d    = s1Valid_q;
    s1MemToReg_d = s1MemToReg_q;
    s1RegWrite_d = s1RegWrite_q;
    s1ReadData_d = s1ReadData_q;
    s1Address_d  = s1Address_q;
    s1Dest_d     = s1Dest_q;
    s1LoadMode_d = s1LoadMode_q;
    if (!stall) begin
      s1Valid_d    = in_valid;
      s1MemToReg_d = in_mem_to_reg;
      s1RegWrite_d = in_reg_write;
      s1ReadData_d = in_read_data;
      s1Address_d  = in_address;
      s1Dest_d     = in_dest;
      s1LoadMode_d = in_load_mode;
    end
    if (flush) begin
      s1Valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1Valid_q    <= 1'b0;
      s1MemToReg_q <= 1'b0;
      s1RegWrite_q <= 1'b0;
      s1ReadData_q <= '0;
      s1Address_q  <= '0;
      s1Dest_q     <= '0;
      s1LoadMode_q <= 2'b00;
    end else begin
      s1Valid_q    <= s1Valid_d;
      s1MemToReg_q <= s1MemToReg_d;
      s1RegWrite_q <= s1RegWrite_d;
      s1ReadData_q <= s1ReadData_d;
      s1Address_q  <= s1Address_d;
      s1Dest_q     <= s1Dest_d;
      s1LoadMode_q <= s1LoadMode_d;
    end
  end

  // Little-endian lanes: address bits pick the lane, lane 0 is bits 7:0
  always_comb begin
    halfSel = s1Address_q[1] ? s1ReadData_q[31:16] : s1ReadData_q[15:0];
    case (s1Address_q[1:0])
      2'd0:    byteSel = s1ReadData_q[7:0];
      2'd1:    byteSel = s1ReadData_q[15:8];
      2'd2:    byteSel = s1ReadData_q[23:16];
      default: byteSel = s1ReadData_q[31:24];
    endcase
    wbValue = s1Address_q;
    if (s1MemToReg_q) begin
      case (s1LoadMode_q)
        2'b00:   wbValue = s1ReadData_q;
        2'b01:   wbValue = {{(DATA_W-16){halfSel[15]}}, halfSel};
        2'b10:   wbValue = {{(DATA_W-8){byteSel[7]}}, byteSel};
        default: wbValue = {{(DATA_W-8){1'b0}}, byteSel};
      endcase
    end
  end

  assign s1Writes   = s1Valid_q && s1RegWrite_q && (s1Dest_q != '0);
  assign s1Misalign = s1Valid_q && s1MemToReg_q &&
                      (((s1LoadMode_q == 2'b00) && (s1Address_q[1:0] != 2'b00)) ||
                       ((s1LoadMode_q == 2'b01) && s1Address_q[0]));
  assign s2Capture  = !stall;

  // A stall injects a bubble here, so the held latch entry writes exactly once after release
  always_comb begin
    rfWe_d       = 1'b0;
    rfWaddr_d    = rfWaddr_q;
    rfWdata_d    = rfWdata_q;
    rfLoadMode_d = rfLoadMode_q;
    misalign_d   = misalign_q;
    if (s2Capture) begin
      rfWe_d       = s1Writes;
      rfWaddr_d    = s1Dest_q;
      rfWdata_d    = wbValue;
      rfLoadMode_d = s1LoadMode_q;
      misalign_d   = misalign_q | s1Misalign;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rfWe_q       <= 1'b0;
      rfWaddr_q    <= '0;
      rfWdata_q    <= '0;
      rfLoadMode_q <= 2'b00;
      misalign_q   <= 1'b0;
    end else begin
      rfWe_q       <= rfWe_d;
      rfWaddr_q    <= rfWaddr_d;
      rfWdata_q    <= rfWdata_d;
      rfLoadMode_q <= rfLoadMode_d;
      misalign_q   <= misalign_d;
    end
  end

  assign rf_we        = rfWe_q;
  assign rf_waddr     = rfWaddr_q;
  assign rf_wdata     = rfWdata_q;
  assign rf_load_mode = rfLoadMode_q;
  assign misalign_err = misalign_q;

  // The latch holds the younger instruction, so it takes priority over the write port
  always_comb begin
    fwd_valid = 1'b0;
    fwd_dest  = '0;
    fwd_data  = '0;
    if (s1Writes) begin
      fwd_valid = 1'b1;
      fwd_dest  = s1Dest_q;
      fwd_data  = wbValue;
    end else if (rfWe_q) begin
      fwd_valid = 1'b1;
      fwd_dest  = rfWaddr_q;
      fwd_data  = rfWdata_q;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retCnt_q, retCnt_d;

  always_comb begin
    retCnt_d = retCnt_q;
    if (s2Capture && s1Valid_q) begin
      retCnt_d = retCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      retCnt_q <= '0;
    end else begin
      retCnt_q <= retCnt_d;
    end
  end

  assign retired_count = retCnt_q;
`else
  assign retired_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed loads/ALU ops, stall/flush, forwarding, misalign, reset.
// Tracks WB_RETIRE_CNT_EN the same way as the design to pick the expected retired_count.
`timescale 1ns/1ps
module tb_wb_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_mem_to_reg;
  logic        in_reg_write;
  logic [31:0] in_read_data;
  logic [31:0] in_address;
  logic [4:0]  in_dest;
  logic [1:0]  in_load_mode;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  rf_load_mode;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        misalign_err;
  logic [31:0] retired_count;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [1:0]  mode;
  } wr_t;

  wr_t         expQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  int unsigned expRetired = 0;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_read_data(in_read_data), .in_address(in_address), .in_dest(in_dest),
    .in_load_mode(in_load_mode),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_load_mode(rf_load_mode),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .misalign_err(misalign_err), .retired_count(retired_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Every write the DUT presents must match the oldest expected write, in order
  always @(negedge CLK) begin
    wr_t exp;
    if (rf_we === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("spuriousWrite", {31'b0, rf_we}, 32'h0);
      end else begin
        exp = expQ.pop_front();
        checkOutput("rf_waddr", {27'b0, rf_waddr}, {27'b0, exp.dest});
        checkOutput("rf_wdata", rf_wdata, exp.data);
        checkOutput("rf_load_mode", {30'b0, rf_load_mode}, {30'b0, exp.mode});
      end
    end
  end

  task automatic applyStimulus(input logic m2r, input logic rw, input logic [31:0] data,
                               input logic [31:0] addr, input logic [4:0] dest,
                               input logic [1:0] mode, input logic [31:0] expData,
                               input logic killed);
    in_valid      = 1'b1;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_read_data  = data;
    in_address    = addr;
    in_dest       = dest;
    in_load_mode  = mode;
    if (!killed) begin
      expRetired++;
      if (rw && dest != 5'd0) expQ.push_back('{dest: dest, data: expData, mode: mode});
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic checkCount();
    logic [31:0] exp;
`ifdef WB_RETIRE_CNT_EN
    exp = expRetired;
`else
    exp = 32'h0;
`endif
    checkOutput("retired_count", retired_count, exp);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".rf_we"}, {31'b0, rf_we}, 32'h0);
    checkOutput({tag, ".rf_waddr"}, {27'b0, rf_waddr}, 32'h0);
    checkOutput({tag, ".rf_wdata"}, rf_wdata, 32'h0);
    checkOutput({tag, ".rf_load_mode"}, {30'b0, rf_load_mode}, 32'h0);
    checkOutput({tag, ".fwd_valid"}, {31'b0, fwd_valid}, 32'h0);
    checkOutput({tag, ".fwd_dest"}, {27'b0, fwd_dest}, 32'h0);
    checkOutput({tag, ".fwd_data"}, fwd_data, 32'h0);
    checkOutput({tag, ".misalign_err"}, {31'b0, misalign_err}, 32'h0);
    checkOutput({tag, ".retired_count"}, retired_count, 32'h0);
  endtask

  initial begin
    RST = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_mem_to_reg = 1'b0; in_reg_write = 1'b0;
    in_read_data = '0; in_address = '0; in_dest = '0; in_load_mode = 2'b00;
    idle(3);
    checkAllZero("reset");
    RST = 1'b0;

    $display("[TB] word load, one-cycle write pulse");
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 32'h100, 5'd8, 2'b00, 32'hDEADBEEF, 1'b0);
    checkOutput("fwdLatch.valid", {31'b0, fwd_valid}, 32'h1);
    checkOutput("fwdLatch.dest", {27'b0, fwd_dest}, 32'd8);
    checkOutput("fwdLatch.data", fwd_data, 32'hDEADBEEF);
    checkOutput("lwNotYet.rf_we", {31'b0, rf_we}, 32'h0);
    idle(1);
    checkOutput("lwWrite.rf_we", {31'b0, rf_we}, 32'h1);
    idle(1);
    checkOutput("lwPulse.rf_we", {31'b0, rf_we}, 32'h0);

    $display("[TB] sub-word loads and ALU ops back to back");
    applyStimulus(1'b1, 1'b1, 32'h80123456, 32'h103, 5'd9,  2'b10, 32'hFFFFFF80, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h80123456, 32'h103, 5'd10, 2'b11, 32'h00000080, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h80011234, 32'h102, 5'd11, 2'b01, 32'hFFFF8001, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h12347FFE, 32'h100, 5'd18, 2'b01, 32'h00007FFE, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h00009A00, 32'h101, 5'd19, 2'b11, 32'h0000009A, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 5'd0, 2'b00, 32'h12345678, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 5'd12, 2'b00, 32'hCAFEF00D, 1'b0);
    idle(3);
    checkCount();
    checkOutput("aligned.misalign_err", {31'b0, misalign_err}, 32'h0);

    $display("[TB] stall for three cycles");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h55, 5'd13, 2'b00, 32'h55, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      checkOutput("stall.rf_we", {31'b0, rf_we}, 32'h0);
      checkOutput("stall.fwd_dest", {27'b0, fwd_dest}, 32'd13);
    end
    stall = 1'b0;
    idle(1);
    checkOutput("afterStall.rf_we", {31'b0, rf_we}, 32'h1);
    idle(3);
    checkCount();

    $display("[TB] flush with stall, and flush at capture");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h77, 5'd14, 2'b00, 32'h77, 1'b1);
    stall = 1'b1; flush = 1'b1;
    @(posedge CLK); #1;
    stall = 1'b0; flush = 1'b0;
    checkOutput("flushStall.fwd_valid", {31'b0, fwd_valid}, 32'h0);
    flush = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h99, 5'd20, 2'b00, 32'h99, 1'b1);
    flush = 1'b0;
    checkOutput("flushCapture.fwd_valid", {31'b0, fwd_valid}, 32'h0);
    idle(3);
    checkCount();

    $display("[TB] forwarding priority");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h11, 5'd5, 2'b00, 32'h11, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h22, 5'd5, 2'b00, 32'h22, 1'b0);
    checkOutput("fwdBoth.valid", {31'b0, fwd_valid}, 32'h1);
    checkOutput("fwdBoth.dest", {27'b0, fwd_dest}, 32'd5);
    checkOutput("fwdBoth.data", fwd_data, 32'h22);
    idle(1);
    checkOutput("fwdPort.data", fwd_data, 32'h22);
    idle(1);
    checkOutput("fwdNone.valid", {31'b0, fwd_valid}, 32'h0);
    checkOutput("fwdNone.data", fwd_data, 32'h0);

    $display("[TB] misaligned word load");
    applyStimulus(1'b1, 1'b1, 32'h01020304, 32'h102, 5'd15, 2'b00, 32'h01020304, 1'b0);
    checkOutput("misalignPending", {31'b0, misalign_err}, 32'h0);
    idle(1);
    checkOutput("misalignSet", {31'b0, misalign_err}, 32'h1);
    idle(4);
    checkOutput("misalignSticky", {31'b0, misalign_err}, 32'h1);

    $display("[TB] reset mid-stream beats stall and flush");
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hAA, 5'd16, 2'b00, 32'hAA, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h0, 32'hBB, 5'd17, 2'b00, 32'hBB, 1'b1);
    RST = 1'b1; stall = 1'b1; flush = 1'b1;
    @(posedge CLK); #1;
    expRetired = 0;
    checkAllZero("midReset");
    RST = 1'b0; stall = 1'b0; flush = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h3C, 5'd7, 2'b00, 32'h3C, 1'b0);
    idle(3);
    checkCount();
    checkOutput("postReset.misalign_err", {31'b0, misalign_err}, 32'h0);

    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
